rr_arb_8: RTL and testbench
===========================

RR_ARB_8 -- requirements
Module: rr_arb_8

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 8, giving the maximum number of cycles one grant is held (legal range 1-15).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1, the reset, synchronous and active-high.
REQ-004 SHALL provide port req, input, 8, request lines; req[i] high means requester i wants the shared 8:1 mux.
REQ-005 SHALL provide port done, input, 1, asserted by the current owner to release its grant.
REQ-006 SHALL provide port gnt, output, 8, one-hot grant, or all zero when nobody owns the mux.
REQ-007 SHALL provide port sel, output, 3, the mux select, equal to the binary index of the granted requester.
REQ-008 SHALL provide port busy, output, 1, high while any grant is active.
REQ-009 SHALL provide port timeout, output, 1, a one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one owner).
REQ-011 SHALL, in IDLE with req != 0, enter GRANT on the next edge with gnt = one-hot(winner), sel = winner and busy = 1.
REQ-012 SHALL select as winner the first i with req[i] = 1, searching upward from index ptr with wrap 7->0.
REQ-013 SHALL hold a 3-bit ptr register, updated to (owner+1) mod 8 on every release (7 wraps to 0).
REQ-014 SHALL, in IDLE with req == 0, stay in IDLE with gnt = 0 and busy = 0; sel SHALL hold its last value.
REQ-015 SHALL keep gnt, sel and the owner stable throughout GRANT, regardless of other req changes.
REQ-016 SHALL keep a 4-bit hold counter that is cleared to 0 on grant entry and increments each GRANT cycle.
REQ-017 SHALL release, returning to IDLE with gnt = 0 on the next edge, when done = 1, or req[owner] = 0, or the hold counter = MAX_HOLD-1.
REQ-018 SHALL pulse timeout for exactly one cycle, coincident with the IDLE cycle, only when release is caused solely by the hold limit (done = 0 and req[owner] = 1).
REQ-019 SHALL give done or a dropped request priority over the hold limit when they coincide, with no timeout pulse.
REQ-020 SHALL always spend exactly one IDLE cycle between consecutive grants (grant gap = 1 cycle).
REQ-021 SHALL ignore done while in IDLE.
REQ-022 SHALL never assert more than one gnt bit, and SHALL keep gnt = 0 whenever busy = 0.
REQ-023 SHALL produce a grant latency of 1 cycle from req rising in IDLE to the corresponding gnt bit.

Reset
REQ-024 SHALL, on reset = 1 at a clock edge, force state = IDLE, gnt = 0, sel = 0, busy = 0, timeout = 0, ptr = 0 and hold counter = 0.
REQ-025 SHALL treat reset asserted mid-GRANT identically, dropping the grant on that edge without a timeout pulse.
REQ-026 SHALL, on the first edge after reset deasserts with req pending, arbitrate from ptr = 0.

Verification
REQ-027 SHALL cover: reset, then req = 8'h01 -> next cycle gnt = 8'h01, sel = 0, busy = 1; done = 1 -> next cycle gnt = 0, ptr = 1.
REQ-028 SHALL cover: req = 8'hFF held, with done pulsed each grant -> grant order 0,1,...,7,0 with one idle cycle between grants.
REQ-029 SHALL cover: MAX_HOLD = 4, req = 8'h20 held, done = 0 -> gnt = 8'h20 for 4 cycles, then gnt = 0 with timeout = 1 for one cycle, then regrant of 5.
REQ-030 SHALL cover: ptr = 7 with req = 8'h81 -> gnt = 8'h80 (sel = 7); after release, ptr = 0 and gnt = 8'h01 (wrap-around).
REQ-031 SHALL cover: done and the hold limit in the same cycle -> release with timeout = 0.
REQ-032 SHALL cover: reset asserted during GRANT of requester 3 -> next cycle gnt = 0, sel = 0, timeout = 0; a pending req = 8'h08 is regranted from ptr = 0.

Source files
------------

// File: rtl/rr_arb_8.sv
// Round-robin arbiter for a shared 8:1 mux with a per-grant hold limit.
// One owner at a time, and always one idle cycle between grants.
module rr_arb_8 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout,
  output logic       dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
  logic [2:0] winner;
  logic [2:0] idx;

  // Scan downward so the requester closest to ptr is the last one written.
  always_comb begin
    winner = ptr_q;
    idx    = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_q + 3'(k);
      if (req[idx]) winner = idx;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          owner_d = winner;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        // A voluntary release wins over the hold limit, so no timeout then.
        if (done || !req[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q + 3'd1;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = ST_IDLE;
          ptr_d     = owner_q + 3'd1;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == ST_GRANT) gnt[owner_q] = 1'b1;
  end

  assign sel       = owner_q;
  assign busy      = (state_q == ST_GRANT);
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_arb_8.sv
// Bench for rr_arb_8: directed vector table, grant-order sequence and a
// randomized run checked against a behavioural round-robin model.
module tb_rr_arb_8;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;
  logic       dbg_state;

  int checks = 0;
  int errors = 0;

  rr_arb_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .timeout  (timeout),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who owns the mux, for how many cycles, and where the
  // round-robin search starts next time.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cycles;
  bit m_timeout;

  function automatic int pick(input logic [7:0] rq, input int start);
    int w;
    bit found;
    w = start;
    found = 0;
    for (int k = 0; k < 8; k++) begin
      if (!found && rq[(start + k) % 8]) begin
        w = (start + k) % 8;
        found = 1;
      end
    end
    return w;
  endfunction

  task automatic mdl_step(input logic r, input logic [7:0] rq, input logic d);
    m_timeout = 0;
    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cycles = 0;
    end else if (!m_busy) begin
      if (rq != 0) begin
        m_owner  = pick(rq, m_ptr);
        m_busy   = 1;
        m_cycles = 1;
      end
    end else if (d || !rq[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % 8;
    end else if (m_cycles == int'(MAX_HOLD)) begin
      m_busy    = 0;
      m_ptr     = (m_owner + 1) % 8;
      m_timeout = 1;
    end else begin
      m_cycles++;
    end
  endtask

  // Driver: inputs change on the falling edge, outputs read on the next one.
  task automatic cyc(input logic r, input logic [7:0] rq, input logic d);
    reset = r;
    req   = rq;
    done  = d;
    @(posedge clk);
    mdl_step(r, rq, d);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int tag, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic chk_model(input string phase, input int tag);
    logic [7:0] eg;
    eg = '0;
    if (m_busy) eg[m_owner] = 1'b1;
    chk({phase, ".gnt"}, tag, gnt, eg);
    chk({phase, ".busy"}, tag, {7'd0, busy}, {7'd0, m_busy});
    chk({phase, ".timeout"}, tag, {7'd0, timeout}, {7'd0, m_timeout});
    chk({phase, ".state"}, tag, {7'd0, dbg_state}, {7'd0, m_busy});
    if (m_busy) chk({phase, ".sel"}, tag, {5'd0, sel}, 8'(m_owner));
    chk({phase, ".ptr"}, tag, {5'd0, dut.ptr_q}, 8'(m_ptr));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] rq;
    logic       dn;
    logic [7:0] e_gnt;
    logic [2:0] e_sel;
    logic       e_busy;
    logic       e_to;
    logic [2:0] e_ptr;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];

  initial begin
    logic [7:0] rq_r;
    logic [7:0] e;

    // reset, single requester, done release
    vecs.push_back(vec_t'{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0});
    vecs.push_back(vec_t'{1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 3'd0});
    vecs.push_back(vec_t'{1'b0, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1});
    vecs.push_back(vec_t'{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1});
    // drive ptr to 7, then wrap-around with req = 81
    vecs.push_back(vec_t'{1'b0, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, 3'd1});
    vecs.push_back(vec_t'{1'b0, 8'h40, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0, 3'd7});
    vecs.push_back(vec_t'{1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, 3'd7});
    vecs.push_back(vec_t'{1'b0, 8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 3'd0});
    vecs.push_back(vec_t'{1'b0, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 3'd0});
    vecs.push_back(vec_t'{1'b0, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1});
    // hold limit: 4 grant cycles, timeout, regrant of 5
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd1});
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd1});
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd1});
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd1});
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b0, 8'h00, 3'd5, 1'b0, 1'b1, 3'd6});
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd6});
    // done coinciding with the hold limit: release without timeout
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd6});
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd6});
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd6});
    vecs.push_back(vec_t'{1'b0, 8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, 3'd6});
    // reset mid-grant of requester 3, regrant from ptr 0
    vecs.push_back(vec_t'{1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd6});
    vecs.push_back(vec_t'{1'b1, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0});
    vecs.push_back(vec_t'{1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd0});
    // dropped request releases; done in IDLE is ignored
    vecs.push_back(vec_t'{1'b0, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 3'd4});
    vecs.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 3'd4});
    vecs.push_back(vec_t'{1'b0, 8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0, 3'd4});
    vecs.push_back(vec_t'{1'b0, 8'h10, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 3'd5});

    reset = 1'b1;
    req   = '0;
    done  = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].rq, vecs[i].dn);
      chk("vec.gnt", i, gnt, vecs[i].e_gnt);
      chk("vec.sel", i, {5'd0, sel}, {5'd0, vecs[i].e_sel});
      chk("vec.busy", i, {7'd0, busy}, {7'd0, vecs[i].e_busy});
      chk("vec.timeout", i, {7'd0, timeout}, {7'd0, vecs[i].e_to});
      chk("vec.ptr", i, {5'd0, dut.ptr_q}, {5'd0, vecs[i].e_ptr});
    end

    // All requesting, done pulsed every grant: order 0..7,0 with one idle gap.
    cyc(1'b1, 8'h00, 1'b0);
    chk_model("order_rst", 0);
    for (int n = 0; n < 8; n++) exp_q.push_back(8'(n));
    exp_q.push_back(8'h00);
    for (int n = 0; n < 9; n++) begin
      cyc(1'b0, 8'hFF, 1'b0);
      chk_model("order", n);
      e = exp_q.pop_front();
      chk("order.sel", n, {5'd0, sel}, e);
      chk("order.busy", n, {7'd0, busy}, 8'h01);
      cyc(1'b0, 8'hFF, 1'b1);
      chk("order.gap", n, gnt, 8'h00);
    end

    // Randomized traffic against the model.
    cyc(1'b1, 8'h00, 1'b0);
    rq_r = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0)
        rq_r = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 149) == 0), rq_r, ($urandom_range(0, 6) == 0));
      chk_model("rand", n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Structural invariants checked every cycle.
  always @(negedge clk) begin
    if (!$isunknown(gnt)) begin
      checks++;
      if (!$onehot0(gnt) || (busy == 1'b0 && gnt != 8'h00)) begin
        errors++;
        $display("FAIL inv.gnt: got %0h busy %0b expected one-hot-or-zero", gnt, busy);
      end
    end
  end

endmodule
